pc_addr_unit: RTL and testbench
===============================

// Module: pc_addr_unit
// PURPOSE
//  Program-counter and memory-address stage driven by the controller FSM.
//  Holds PC and the data-address register, and computes next-PC from the one-hot branch_sel.
//  Drives the memory address (PC for fetch, data address for LDR/STR) and pc_out (link value, vsel=01).
//  Keeps a saturating retired-fetch counter and a sticky select-error flag for debug.
// PARAMETERS
//  AW  9   memory word-address width (PC, data address, mem_addr)
//  DW  16  datapath word width (datapath_out, sximm8)
//  CW  16  width of fetch counter
// PORTS
//  clk           in   1   rising-edge clock
//  reset_n       in   1   synchronous, active-low reset
//  reset_pc      in   1   from FSM: next-PC source = 0 when load_pc
//  load_pc       in   1   from FSM: PC <= next_pc
//  branch_sel    in   4   from FSM, one-hot: 1000 hold, 0100 PC+1, 0010 PC+sximm8, 0001 reg target
//  sximm8        in   DW  sign-extended 8-bit branch offset from decoder
//  datapath_out  in   DW  datapath C result (BX/BLX target; LDR/STR address)
//  load_addr     in   1   from FSM: data_addr <= datapath_out[AW-1:0]
//  addr_sel      in   1   from FSM: 1 -> mem_addr = PC, 0 -> mem_addr = data_addr
//  load_ir       in   1   from FSM: instruction fetched (counter event)
//  halt          in   1   from FSM: freezes PC, data_addr and counter
//  pc_out        out  AW  current PC (link value for BL/BLX)
//  mem_addr      out  AW  memory word address, combinational mux
//  fetch_count   out  CW  number of load_ir events, saturating
//  sel_err       out  1   sticky: load_pc seen with illegal branch_sel
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): pc=0, data_addr=0, fetch_count=0, sel_err=0.
//   Then mem_addr = addr_sel ? 0 : 0. reset_n dominates every other input.
//  next_pc (combinational):
//   reset_pc=1 -> 0, regardless of branch_sel.
//   1000 -> pc. 0100 -> pc+1. 0010 -> pc + sximm8[AW-1:0]. 0001 -> datapath_out[AW-1:0].
//   All sums are truncated to AW bits, so they wrap mod 2^AW: pc=511, +1 -> 0; pc=0, sximm8=-1 -> 511.
//   Any other branch_sel (zero or multi-hot) with reset_pc=0 -> next_pc = pc.
//  PC register: on posedge, if reset_n & load_pc & ~halt, pc <= next_pc. Latency is 1 cycle.
//   pc_out = pc (registered).
//  sel_err: set on posedge when reset_n & load_pc & ~halt & ~reset_pc and branch_sel is not one-hot.
//   Only reset_n clears it.
//  data_addr: on posedge, if reset_n & load_addr & ~halt, data_addr <= datapath_out[AW-1:0].
//  mem_addr = addr_sel ? pc : data_addr. It is combinational and same-cycle with addr_sel.
//  fetch_count: on posedge, if reset_n & load_ir & ~halt & (fetch_count != 2^CW-1), increment by 1.
//   Saturates at all-ones.
//  Simultaneous events:
//   load_pc and load_addr in the same cycle: both registers update independently.
//   load_ir with load_pc: the counter and PC both update.
//  Halt: while halt=1 every register holds. Outputs stay valid, and mem_addr still follows addr_sel.
//   Deasserting halt resumes normally from the held state.
//  Reset mid-operation: asserting reset_n=0 in any cycle discards pending loads at that edge.
//   The next cycle sees pc=0.
//  No internal state machine beyond the registers.
//   Correct fetch sequencing is the FSM's job: RST/IF1/IF2/UpdatePC (reset_pc+load_pc, then addr_sel fetch, then PC+1).
// TESTING
//  1. Reset: reset_n=0 with load_pc=1, branch_sel=0100 -> pc=0, fetch_count=0, sel_err=0 after the edge.
//  2. Increment and wrap: pc=510, load_pc with 0100 twice -> pc=511 then 0. addr_sel=1 -> mem_addr tracks pc.
//  3. Branch: pc=20, sximm8=16'hFFFB (-5), 0010 -> pc=15. pc=3, sximm8=-5 -> pc=510 (wrap).
//  4. BX and LDR address: datapath_out=16'h0123 with 0001+load_pc -> pc=0x123.
//     load_addr with datapath_out=16'hFF40 -> data_addr=0x140. addr_sel=0 -> mem_addr=0x140.
//  5. Illegal select and halt: branch_sel=0110+load_pc -> pc unchanged, sel_err=1 and it stays set.
//     halt=1 with load_pc/load_addr/load_ir -> no register changes.
//  6. Counter saturation: preload to 16'hFFFE (CW=16), 3 load_ir pulses -> FFFF, FFFF, FFFF.
//     reset_n=0 -> 0.

Source files
------------

// File: rtl/pc_addr_unit_if.sv
// Control, operand and address bundle between the controller FSM and the
// program-counter / memory-address unit.
interface pc_addr_unit_if #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          reset_pc;
    logic          load_pc;
    logic [3:0]    branch_sel;
    logic [DW-1:0] sximm8;
    logic [DW-1:0] datapath_out;
    logic          load_addr;
    logic          addr_sel;
    logic          load_ir;
    logic          halt;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] fetch_count;
    logic          sel_err;

    // FSM / datapath side
    modport master (
        output reset_pc, load_pc, branch_sel, sximm8, datapath_out,
        output load_addr, addr_sel, load_ir, halt,
        input  pc_out, mem_addr, fetch_count, sel_err
    );

    // Address unit side
    modport slave (
        input  reset_pc, load_pc, branch_sel, sximm8, datapath_out,
        input  load_addr, addr_sel, load_ir, halt,
        output pc_out, mem_addr, fetch_count, sel_err
    );
endinterface

// File: rtl/pc_addr_unit.sv
// Program counter, data-address register and memory address mux,
// with a saturating fetch counter and sticky select-error flag.
module pc_addr_unit #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input logic           clk,
    input logic           reset_n,
    pc_addr_unit_if.slave bus
);
    logic [AW-1:0] pc;
    logic [AW-1:0] data_addr;
    logic [AW-1:0] next_pc;
    logic [CW-1:0] fcnt;
    logic          err;
    logic          sel_ok;
    logic          pc_we;
    logic          unused_hi;

    // Upper operand bits lie outside the word-address space.
    assign unused_hi = ^{bus.sximm8[DW-1:AW], bus.datapath_out[DW-1:AW]};

    assign sel_ok = $onehot(bus.branch_sel);
    assign pc_we  = bus.load_pc & ~bus.halt;

    // Next-PC select; sums wrap mod 2^AW, illegal selects hold.
    always_comb begin
        next_pc = pc;
        if (bus.reset_pc) begin
            next_pc = '0;
        end else begin
            case (bus.branch_sel)
                4'b1000: next_pc = pc;
                4'b0100: next_pc = pc + AW'(1);
                4'b0010: next_pc = pc + bus.sximm8[AW-1:0];
                4'b0001: next_pc = bus.datapath_out[AW-1:0];
                default: next_pc = pc;
            endcase
        end
    end

    // PC, data address, fetch counter and error flag; halt freezes all.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc        <= '0;
            data_addr <= '0;
            fcnt      <= '0;
            err       <= 1'b0;
        end else begin
            if (pc_we)
                pc <= next_pc;
            if (pc_we && !bus.reset_pc && !sel_ok)
                err <= 1'b1;
            if (bus.load_addr && !bus.halt)
                data_addr <= bus.datapath_out[AW-1:0];
            if (bus.load_ir && !bus.halt && (fcnt != {CW{1'b1}}))
                fcnt <= fcnt + CW'(1);
        end
    end

    assign bus.pc_out      = pc;
    assign bus.mem_addr    = bus.addr_sel ? pc : data_addr;
    assign bus.fetch_count = fcnt;
    assign bus.sel_err     = err;
endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_pc_addr_unit;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int CW = 16;

    typedef struct {
        string          nm;
        logic [AW-1:0]  pc;
        logic [AW-1:0]  ma;
        logic [CW-1:0]  fc;
        logic           se;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;

    pc_addr_unit_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    pc_addr_unit #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                vecs++;
                if (bus.pc_out !== e.pc || bus.mem_addr !== e.ma ||
                    bus.fetch_count !== e.fc || bus.sel_err !== e.se) begin
                    errs++;
                    $display("FAIL %s: got pc=%h ma=%h fc=%h se=%b want pc=%h ma=%h fc=%h se=%b",
                             e.nm, bus.pc_out, bus.mem_addr, bus.fetch_count,
                             bus.sel_err, e.pc, e.ma, e.fc, e.se);
                end
            end
        end
    end

    task automatic idle();
        bus.reset_pc     = 1'b0;
        bus.load_pc      = 1'b0;
        bus.load_addr    = 1'b0;
        bus.load_ir      = 1'b0;
        bus.branch_sel   = 4'b1000;
    endtask

    task automatic push(input string nm, input logic [AW-1:0] pc,
                        input logic [AW-1:0] ma, input logic [CW-1:0] fc,
                        input logic se);
        exp_t e;
        e.nm = nm;
        e.pc = pc;
        e.ma = ma;
        e.fc = fc;
        e.se = se;
        q.push_back(e);
    endtask

    // Clock the current stimulus in, clear strobes, queue the expectation.
    task automatic clk_vec(input string nm, input logic [AW-1:0] pc,
                           input logic [AW-1:0] ma, input logic [CW-1:0] fc,
                           input logic se);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        push(nm, pc, ma, fc, se);
        @(negedge clk);
        #1;
    endtask

    // Check combinational outputs with no clock edge in between.
    task automatic comb_vec(input string nm, input logic [AW-1:0] pc,
                            input logic [AW-1:0] ma, input logic [CW-1:0] fc,
                            input logic se);
        push(nm, pc, ma, fc, se);
        @(negedge clk);
        #1;
    endtask

    task automatic bx(input logic [DW-1:0] tgt);
        bus.branch_sel   = 4'b0001;
        bus.datapath_out = tgt;
        bus.load_pc      = 1'b1;
    endtask

    initial begin
        idle();
        bus.sximm8       = '0;
        bus.datapath_out = '0;
        bus.addr_sel     = 1'b1;
        bus.halt         = 1'b0;

        // Reset dominates load_pc / load_ir
        reset_n        = 1'b0;
        bus.load_pc    = 1'b1;
        bus.branch_sel = 4'b0100;
        bus.load_ir    = 1'b1;
        clk_vec("reset", 9'd0, 9'd0, 16'd0, 1'b0);

        // Increment and wrap
        bx(16'd510);
        clk_vec("bx510", 9'd510, 9'd510, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        clk_vec("inc511", 9'd511, 9'd511, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        clk_vec("incwrap", 9'd0, 9'd0, 16'd0, 1'b0);

        // Relative branches
        bx(16'd20);
        clk_vec("bx20", 9'd20, 9'd20, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0010; bus.sximm8 = 16'hFFFB;
        clk_vec("br_m5", 9'd15, 9'd15, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b1000;
        clk_vec("hold", 9'd15, 9'd15, 16'd0, 1'b0);
        bx(16'd3);
        clk_vec("bx3", 9'd3, 9'd3, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0010; bus.sximm8 = 16'hFFFB;
        clk_vec("br_wrap", 9'd510, 9'd510, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.reset_pc = 1'b1; bus.branch_sel = 4'b0010;
        clk_vec("reset_pc", 9'd0, 9'd0, 16'd0, 1'b0);

        // BX target, then data address with simultaneous PC+1
        bx(16'h0123);
        clk_vec("bx123", 9'h123, 9'h123, 16'd0, 1'b0);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        bus.load_addr = 1'b1; bus.datapath_out = 16'hFF40;
        bus.addr_sel = 1'b0;
        clk_vec("ldr_addr", 9'h124, 9'h140, 16'd0, 1'b0);
        bus.addr_sel = 1'b1;
        comb_vec("mux_pc", 9'h124, 9'h124, 16'd0, 1'b0);

        // Illegal select is sticky
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0110;
        clk_vec("illegal", 9'h124, 9'h124, 16'd0, 1'b1);
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        clk_vec("sticky", 9'h125, 9'h125, 16'd0, 1'b1);

        // Halt freezes everything but the mux
        bus.halt = 1'b1; bus.addr_sel = 1'b0;
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        bus.load_addr = 1'b1; bus.datapath_out = 16'h0055;
        bus.load_ir = 1'b1;
        clk_vec("halt", 9'h125, 9'h140, 16'd0, 1'b1);
        bus.addr_sel = 1'b1;
        comb_vec("halt_mux", 9'h125, 9'h125, 16'd0, 1'b1);
        bus.halt = 1'b0;
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100; bus.load_ir = 1'b1;
        clk_vec("resume", 9'h126, 9'h126, 16'd1, 1'b1);

        // Counter preload to FFFE, then saturate
        bus.load_ir = 1'b1;
        repeat (65533) @(posedge clk);
        #1;
        bus.load_ir = 1'b0;
        comb_vec("cnt_fffe", 9'h126, 9'h126, 16'hFFFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.load_ir = 1'b1;
            clk_vec("cnt_sat", 9'h126, 9'h126, 16'hFFFF, 1'b1);
        end

        // Reset mid-operation discards pending loads
        reset_n = 1'b0;
        bus.load_pc = 1'b1; bus.branch_sel = 4'b0100;
        bus.load_ir = 1'b1; bus.load_addr = 1'b1;
        clk_vec("reset2", 9'd0, 9'd0, 16'd0, 1'b0);
        bus.addr_sel = 1'b0;
        comb_vec("reset2_da", 9'd0, 9'd0, 16'd0, 1'b0);

        @(negedge clk);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
